serial_addsub: RTL and testbench

Bit-serial, multi-cycle adder/subtractor with valid/ready handshakes on operand and result sides. It is the sequential counterpart to the team's combinational ripple-carry adder. It computes A+B+Cin or A−B−Bin one bit per clock, LSB first, through a single full-adder cell. It targets area-constrained paths and serves as a cross-check against the ripple-carry adder in shared benches.

---
 rtl/serial_addsub_pkg.sv | 9 +
 rtl/serial_addsub_full_adder_cell.sv | 16 +
 rtl/serial_addsub.sv | 95 +++++++++
 tb/tb_serial_addsub.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared state encoding and mode constants for the bit-serial adder/subtractor
package serial_addsub_pkg;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_full_adder_cell.sv
// full_adder_cell: single-bit combinational full adder
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   // sum and majority carry
   always_comb begin
      s  = a ^ b ^ ci;
      co = (a & b) | (a & ci) | (b & ci);
   end

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial add/subtract, LSB first through one full adder, valid/ready on both sides
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] result_q;
   logic             mode_q;
   logic             carry_q;
   logic             cout_q;
   logic             ovf_q;
   logic             s_d;
   logic             co_d;

   // subtraction feeds the inverted B bit; the carry flop already holds ~Bin
   full_adder_cell u_fa (
      .a  (a_q[0]),
      .b  (b_q[0] ^ mode_q),
      .ci (carry_q),
      .s  (s_d),
      .co (co_d)
   );

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign result    = result_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

   // FSM: capture operands, shift one bit per edge, hold result until handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         mode_q   <= MODE_ADD;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               a_q     <= a;
               b_q     <= b;
               mode_q  <= mode;
               carry_q <= (mode == MODE_ADD) ? cin : ~cin;
               cnt_q   <= '0;
               state_q <= CALC;
            end
            CALC: begin
               a_q      <= a_q >> 1;
               b_q      <= b_q >> 1;
               carry_q  <= co_d;
               result_q <= {s_d, result_q[WIDTH-1:1]};
               cnt_q    <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  cnt_q   <= '0;
                  cout_q  <= (mode_q == MODE_SUB) ? ~co_d : co_d;
                  ovf_q   <= carry_q ^ co_d;
                  state_q <= DONE;
               end
            end
            DONE: if (out_ready) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed and exhaustive checks of serial_addsub against an arithmetic model
module tb_serial_addsub;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         mode = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;
   logic         busy;

   int n_checks = 0;
   int n_errors = 0;

   serial_addsub #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .ovf       (ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // returns {ovf, cout, result} from integer arithmetic on the operands
   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci, input logic md);
      int ux = x;
      int uy = y;
      int sx = $signed(x);
      int sy = $signed(y);
      int r;
      int s;
      logic c;
      logic o;
      logic [W-1:0] res;
      if (md == 1'b0) begin
         r = ux + uy + ci;
         s = sx + sy + ci;
         c = (r >= (1 << W));
      end else begin
         r = ux - uy - ci;
         s = sx - sy - ci;
         c = (r < 0);
      end
      o   = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
      res = r[W-1:0];
      return {o, c, res};
   endfunction

   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                         input logic md, input int hold, input string tag);
      logic [W+1:0] exp;
      int n;
      exp = model(x, y, ci, md);
      check({tag, " in_ready"}, in_ready, 1'b1);
      in_valid = 1'b1;
      a = x;
      b = y;
      cin = ci;
      mode = md;
      @(negedge clk);
      in_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
      mode = 1'($urandom);
      check({tag, " busy"}, busy, 1'b1);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, " latency"}, n, W);
      check({tag, " result"}, result, exp[W-1:0]);
      check({tag, " cout"}, cout, exp[W]);
      check({tag, " ovf"}, ovf, exp[W+1]);
      for (int i = 0; i < hold; i++) begin
         in_valid = ~in_valid;
         a = W'($urandom);
         b = W'($urandom);
         @(negedge clk);
         check({tag, " hold valid"}, out_valid, 1'b1);
         check({tag, " hold in_ready"}, in_ready, 1'b0);
         check({tag, " hold result"}, {ovf, cout, result}, exp);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, " drop valid"}, out_valid, 1'b0);
      check({tag, " in_ready back"}, in_ready, 1'b1);
      check({tag, " held after hs"}, {ovf, cout, result}, exp);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst in_ready", in_ready, 1'b1);
      check("rst out_valid", out_valid, 1'b0);
      check("rst outs", {ovf, cout, result, busy}, '0);
      rst = 1'b0;
      @(negedge clk);
      run_op(4'b0101, 4'b0011, 1'b0, 1'b0, 0, "add1");
      run_op(4'b1111, 4'b0001, 1'b0, 1'b0, 1, "addwrap");
      run_op(4'b0111, 4'b0000, 1'b1, 1'b0, 0, "addcin");
      run_op(4'b0011, 4'b0101, 1'b0, 1'b1, 0, "sub1");
      run_op(4'b1000, 4'b0001, 1'b0, 1'b1, 2, "subovf");
      run_op(4'b0101, 4'b0101, 1'b1, 1'b1, 0, "subbin");
      run_op(4'b0110, 4'b0111, 1'b1, 1'b0, 5, "bp");
      in_valid = 1'b1;
      a = 4'b0111;
      b = 4'b0111;
      cin = 1'b1;
      mode = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort in_ready", in_ready, 1'b1);
      check("abort out_valid", out_valid, 1'b0);
      check("abort outs", {ovf, cout, result, busy}, '0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_op(4'b0010, 4'b0010, 1'b0, 1'b0, 0, "postrst");
      for (int m = 0; m < 2; m++)
         for (int c = 0; c < 2; c++)
            for (int x = 0; x < 16; x++)
               for (int y = 0; y < 16; y++)
                  run_op(W'(x), W'(y), 1'(c), 1'(m), $urandom_range(0, 3), "sweep");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
